iteration_ctrl_div_sqrt: RTL and testbench

Sequencing controller for the radix-2 non-restoring div/sqrt iteration datapath (first iteration cell plus unrolled iteration chain).
- Accepts single-cycle div or sqrt start requests and latches the operation type and precision.
- Drives the Div/Sqrt enable and first-cycle carry-in controls that the iteration cells consume.
- Counts iteration cycles, then pulses Done so the normalisation/rounding stage captures the partial remainder and quotient.

---
 rtl/iteration_ctrl_div_sqrt.sv | 119 +++++++++++
 tb/tb_iteration_ctrl_div_sqrt.sv | 127 ++++++++++++
 2 files changed

// File: rtl/iteration_ctrl_div_sqrt.sv
// Sequencer for the radix-2 non-restoring div/sqrt iteration chain: accepts a start, loads operands,
// runs ceil(N/UNROLL) iteration cycles and pulses Done. All outputs are Moore decodes of registered state.
module iteration_ctrl_div_sqrt #(
  parameter int QBITS  = 26,
  parameter int UNROLL = 2,
  localparam int CNT_W = $clog2(QBITS/UNROLL+1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Div_start_SI,
  input  logic             Sqrt_start_SI,
  input  logic             Kill_SI,
  input  logic [5:0]       Precision_ctl_SI,
  output logic             Ready_SO,
  output logic             Load_SO,
  output logic             Div_enable_SO,
  output logic             Sqrt_enable_SO,
  output logic             Div_start_dly_SO,
  output logic             Iter_en_SO,
  output logic [CNT_W-1:0] Iter_cnt_DO,
  output logic             Final_iter_SO,
  output logic             Done_SO
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ITER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic [5:0]       prec_q, prec_d;
  logic             first_q, first_d;

  logic [7:0]       prec_n;
  logic [CNT_W-1:0] load_cnt;

  // Zero or out-of-range precision falls back to full precision.
  always_comb begin
    prec_n = {2'b00, prec_q};
    if (prec_q == 6'd0 || {2'b00, prec_q} > 8'(QBITS)) begin
      prec_n = 8'(QBITS);
    end
    load_cnt = CNT_W'((prec_n + 8'(UNROLL-1)) / 8'(UNROLL));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    prec_d   = prec_q;
    first_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Div_start_SI) begin
          state_d  = LOAD;
          op_div_d = 1'b1;
          prec_d   = Precision_ctl_SI;
        end else if (Sqrt_start_SI) begin
          state_d  = LOAD;
          op_div_d = 1'b0;
          prec_d   = Precision_ctl_SI;
        end
      end
      LOAD: begin
        state_d = ITER;
        cnt_d   = load_cnt;
        first_d = 1'b1;
      end
      ITER: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (Kill_SI && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      prec_q   <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      prec_q   <= prec_d;
      first_q  <= first_d;
    end
  end

  logic active;
  assign active = (state_q == LOAD) || (state_q == ITER);

  assign Ready_SO         = (state_q == IDLE);
  assign Load_SO          = (state_q == LOAD);
  assign Div_enable_SO    = active && op_div_q;
  assign Sqrt_enable_SO   = active && !op_div_q;
  assign Div_start_dly_SO = (state_q == ITER) && first_q && op_div_q;
  assign Iter_en_SO       = (state_q == ITER);
  assign Iter_cnt_DO      = cnt_q;
  assign Final_iter_SO    = (state_q == ITER) && (cnt_q == CNT_W'(1));
  assign Done_SO          = (state_q == DONE);

endmodule

// File: tb/tb_iteration_ctrl_div_sqrt.sv
// Directed bench for iteration_ctrl_div_sqrt: every output is compared each cycle against a
// cycle-offset expectation derived from the accepting edge.
module tb_iteration_ctrl_div_sqrt;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       div_start = 1'b0;
  logic       sqrt_start = 1'b0;
  logic       kill = 1'b0;
  logic [5:0] prec = 6'd0;
  logic       ready, load, div_en, sqrt_en, div_dly, iter_en, final_it, done;
  logic [3:0] cnt;

  int passed = 0;
  int total  = 0;

  iteration_ctrl_div_sqrt dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .Div_start_SI(div_start), .Sqrt_start_SI(sqrt_start), .Kill_SI(kill),
    .Precision_ctl_SI(prec),
    .Ready_SO(ready), .Load_SO(load), .Div_enable_SO(div_en), .Sqrt_enable_SO(sqrt_en),
    .Div_start_dly_SO(div_dly), .Iter_en_SO(iter_en), .Iter_cnt_DO(cnt),
    .Final_iter_SO(final_it), .Done_SO(done)
  );

  always #5 clk = ~clk;

  logic [11:0] obs;
  assign obs = {ready, load, div_en, sqrt_en, div_dly, iter_en, final_it, done, cnt};

  // k = cycles after the accepting edge (k=1 is LOAD); kill_k = cycle in which Kill_SI was high.
  function automatic logic [11:0] ev(int k, int c, bit dv, int kill_k);
    logic r, l, de, se, dd, ie, fi, dn;
    logic [3:0] n;
    {r, l, de, se, dd, ie, fi, dn} = 8'h00;
    n = 4'd0;
    if (k <= 0 || k > c + 2 || (kill_k > 0 && k > kill_k)) begin
      r = 1'b1;
    end else if (k == 1) begin
      l = 1'b1; de = dv; se = !dv;
    end else if (k <= c + 1) begin
      ie = 1'b1; de = dv; se = !dv;
      dd = dv && (k == 2);
      fi = (k == c + 1);
      n  = 4'(c - (k - 2));
    end else begin
      dn = 1'b1;
    end
    return {r, l, de, se, dd, ie, fi, dn, n};
  endfunction

  task automatic chk(input string tag, input int k, input logic [11:0] o, input logic [11:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s k=%0d observed=%03h expected=%03h", tag, k, o, e);
  endtask

  // Start an op during one idle cycle, then check every cycle through the return to IDLE.
  task automatic run(input string tag, input bit d, input bit s, input logic [5:0] p,
                     input int c, input bit dv, input int inj_k, input int kill_k, input bit kill0);
    int last;
    last = (kill_k > 0) ? kill_k + 1 : c + 3;
    @(negedge clk);
    div_start = d; sqrt_start = s; prec = p; kill = kill0;
    chk(tag, 0, obs, ev(0, c, dv, kill_k));
    @(posedge clk);
    #1 div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0; prec = 6'h2a;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      chk(tag, k, obs, ev(k, c, dv, kill_k));
      if (k == inj_k) begin
        div_start = 1'b1; sqrt_start = 1'b1; prec = 6'd1;
      end
      if (k == kill_k) kill = 1'b1;
      @(posedge clk);
      #1 div_start = 1'b0; sqrt_start = 1'b0; kill = 1'b0;
    end
  endtask

  initial begin
    #12;
    chk("reset_hold", 0, obs, ev(0, 1, 1'b0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_release", 0, obs, ev(0, 1, 1'b0, 0));

    run("div_full",     1'b1, 1'b0, 6'd0,  13, 1'b1, 0, 0, 1'b0);
    run("sqrt_p7",      1'b0, 1'b1, 6'd7,   4, 1'b0, 0, 0, 1'b0);
    run("both_p1",      1'b1, 1'b1, 6'd1,   1, 1'b1, 0, 0, 1'b0);
    run("clamp_p40",    1'b1, 1'b0, 6'd40, 13, 1'b1, 5, 0, 1'b0);
    run("sqrt_p26",     1'b0, 1'b1, 6'd26, 13, 1'b0, 3, 0, 1'b0);
    run("kill_iter",    1'b1, 1'b0, 6'd0,  13, 1'b1, 0, 6, 1'b0);
    run("after_kill",   1'b0, 1'b1, 6'd3,   2, 1'b0, 0, 0, 1'b0);
    run("kill_load",    1'b0, 1'b1, 6'd12,  6, 1'b0, 0, 1, 1'b0);
    run("kill_done",    1'b0, 1'b1, 6'd9,   5, 1'b0, 0, 7, 1'b0);
    run("kill_in_idle", 1'b1, 1'b0, 6'd4,   2, 1'b1, 0, 0, 1'b1);
    run("div_p27",      1'b1, 1'b0, 6'd27, 13, 1'b1, 0, 0, 1'b0);

    // Asynchronous reset in the middle of a clock phase during ITER.
    @(negedge clk);
    div_start = 1'b1; prec = 6'd0;
    @(posedge clk);
    #1 div_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_iter", 4, obs, ev(4, 13, 1'b1, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 0, obs, ev(0, 13, 1'b1, 0));
    @(posedge clk);
    #1 chk("reset_held_edge", 0, obs, ev(0, 13, 1'b1, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("no_done_after_reset", 0, obs, ev(0, 13, 1'b1, 0));
    run("sqrt_after_rst", 1'b0, 1'b1, 6'd0, 13, 1'b0, 0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
